// File: rtl/twofish_pkg.sv
// Shared definitions for the Twofish q-permutation word engine:
// word geometry, FSM state encoding and the q0/q1 nibble lookup tables.
package twofish_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NBYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Each table packs 16 nibbles with entry 0 in bits [3:0].
  function automatic logic [63:0] tbox_table(input logic q, input logic [1:0] t);
    logic [63:0] tbl;
    tbl = '0;
    case ({q, t})
      3'b0_00: tbl = 64'h4ACE_95B0_23F6_D718;
      3'b0_01: tbl = 64'hD907_6A4F_5321_8BCE;
      3'b0_10: tbl = 64'h1742_3F8C_09D6_E5AB;
      3'b0_11: tbl = 64'hAC58_03B9_E621_4F7D;
      3'b1_00: tbl = 64'h5CA0_4913_E67F_DB82;
      3'b1_01: tbl = 64'h809F_5AD6_73C4_B2E1;
      3'b1_10: tbl = 64'hF3B2_8DE0_A961_57C4;
      3'b1_11: tbl = 64'hA802_F746_ED3C_159B;
      default: tbl = '0;
    endcase
    return tbl;
  endfunction

endpackage

// File: rtl/q_word_engine_tbox.sv
// One 4-bit Twofish lookup box; Q picks the q0/q1 set, T picks t0..t3.
module tBox
  import twofish_pkg::*;
#(
  parameter logic       Q = 1'b0,
  parameter logic [1:0] T = 2'd0
) (
  input  logic [3:0] x,
  output logic [3:0] y
);

  localparam logic [63:0] TBL = tbox_table(Q, T);

  assign y = TBL[{x, 2'b00} +: 4];

endmodule

// File: rtl/q_word_engine.sv
// Applies the Twofish q0/q1 permutation to each byte of a 32-bit word,
// one byte per two cycles (first and second lookup layer), valid/ready on both sides.
module q_word_engine
  import twofish_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [NBYTES-1:0] in_qsel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word
);

  state_t state, state_nx;

  logic [1:0]        idx;
  logic [WORD_W-1:0] word_q;
  logic [NBYTES-1:0] qsel_q;
  logic [WORD_W-1:0] result;
  logic [3:0]        a2_q, b2_q;

  logic              load;
  logic [7:0]        byte_in;
  logic              sel;
  logic [3:0]        a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
  logic [3:0]        tin  [4];
  logic [3:0]        tout [2][4];

  // Layer one uses t0/t1 on (a1,b1); layer two uses t2/t3 on the registered pair.
  assign byte_in = word_q[{idx, 3'b000} +: 8];
  assign sel     = qsel_q[idx];

  assign a0 = byte_in[7:4];
  assign b0 = byte_in[3:0];
  assign a1 = a0 ^ b0;
  assign b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};

  assign a3 = a2_q ^ b2_q;
  assign b3 = a2_q ^ {b2_q[0], b2_q[3:1]} ^ {a2_q[0], 3'b000};

  assign tin[0] = a1;
  assign tin[1] = b1;
  assign tin[2] = a3;
  assign tin[3] = b3;

  for (genvar q = 0; q < 2; q++) begin : g_q
    for (genvar t = 0; t < 4; t++) begin : g_t
      tBox #(
        .Q (1'(q)),
        .T (2'(t))
      ) u_tbox (
        .x (tin[t]),
        .y (tout[q][t])
      );
    end
  end

  assign a2 = sel ? tout[1][0] : tout[0][0];
  assign b2 = sel ? tout[1][1] : tout[0][1];
  assign a4 = sel ? tout[1][2] : tout[0][2];
  assign b4 = sel ? tout[1][3] : tout[0][3];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = L1;
        end
      end
      L1:   state_nx = L2;
      L2:   state_nx = (idx == 2'd3) ? DONE : L1;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      word_q <= '0;
      qsel_q <= '0;
      result <= '0;
      a2_q   <= '0;
      b2_q   <= '0;
    end else begin
      if (load) begin
        word_q <= in_word;
        qsel_q <= in_qsel;
        idx    <= '0;
      end
      if (state == L1) begin
        a2_q <= a2;
        b2_q <= b2;
      end
      if (state == L2) begin
        result[{idx, 3'b000} +: 8] <= {b4, a4};
        if (idx != 2'd3) idx <= idx + 2'd1;
      end
    end
  end

  assign out_word = result;

endmodule

// File: tb/tb_q_word_engine.sv
// Scoreboard bench for q_word_engine: the driver queues expected words at
// accept, a negedge monitor checks them whenever out_valid is presented.
module tb_q_word_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [3:0]  in_qsel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;

  typedef struct {
    logic [31:0] exp;
    int unsigned acc;
  } sb_t;

  sb_t         sbq[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  logic        prev_valid;

  q_word_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_qsel   (in_qsel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle the DUT presents a result.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_valid) chk("latency", cyc - sbq[0].acc, 32'd8);
          chk("out_word", out_word, sbq[0].exp);
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) void'(sbq.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [31:0] w, input logic [3:0] qs, input logic [31:0] exp);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_word  = w;
    in_qsel  = qs;
    @(posedge clk); #1;
    sbq.push_back('{exp: exp, acc: cyc});
    in_valid = 1'b0;
    in_word  = ~w;
    in_qsel  = ~qs;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int unsigned n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    in_qsel   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'h0000_0000);

    send(32'h0000_0000, 4'b0000, 32'hA9A9_A9A9);
    wait_idle();
    send(32'h0000_0000, 4'b1111, 32'h7575_7575);
    wait_idle();
    send(32'h0000_0100, 4'b0101, 32'hA975_6775);
    wait_idle();
    send(32'h0001_0100, 4'b0110, 32'hA9F3_F3A9);
    wait_idle();

    // Back-pressure: hold DONE for five cycles.
    out_ready = 1'b0;
    send(32'h0101_0101, 4'b1010, 32'hF367_F367);
    wait_valid();
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_word", out_word, 32'hF367_F367);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
    wait_idle();

    // Reset while in L2 of byte 2.
    send(32'h1234_5678, 4'b0011, 32'h0000_0000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_word", out_word, 32'h0000_0000);
    send(32'h0000_0100, 4'b0101, 32'hA975_6775);
    wait_idle();

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
